uart_frame_rx: RTL
==================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5000: UART bit period in i_Clock cycles; it matches the paired uart_rx.
REQ-002 Parameter SYNC_MIN, default 4: number of consecutive 8'hFF bytes required to acquire alignment.
REQ-003 Parameter TIMEOUT_BYTES, default 4: inter-byte timeout in byte times; the timeout is CLKS_PER_BIT*10*TIMEOUT_BYTES cycles.
REQ-004 i_Clock  in  1  sole clock, rising edge.
REQ-005 i_Rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_Rx_DV  in  1  one-cycle strobe, received byte valid (from uart_rx o_Rx_DV).
REQ-007 i_Rx_Byte  in  8  received byte, sampled only when i_Rx_DV=1.
REQ-008 i_Resync  in  1  synchronous request to drop alignment and re-hunt.
REQ-009 o_Custom_Cmd  out  8  frame byte 0, held until the next accepted frame.
REQ-010 o_Cmd  out  8  frame byte 1, held until the next accepted frame.
REQ-011 o_Data  out  16  frame bytes 2 (MSB) and 3 (LSB), held until the next accepted frame.
REQ-012 o_Frame_DV  out  1  one-cycle pulse, new frame on o_Custom_Cmd/o_Cmd/o_Data.
REQ-013 o_Synced  out  1  high while aligned (any state other than HUNT).
REQ-014 o_Err  out  1  one-cycle pulse, partial frame dropped on timeout.

Function
REQ-015 Frame format: 4 bytes in order custom_cmd, cmd, data[15:8], data[7:0].
REQ-016 State machine: HUNT, WAIT_B0, GET_B0, GET_B1, GET_B2, GET_B3.
REQ-017 HUNT: each 8'hFF byte increments sync_cnt, saturating at SYNC_MIN; each non-FF byte clears sync_cnt.
REQ-018 HUNT exit: when the SYNC_MIN-th consecutive FF byte is accepted, the next state is WAIT_B0 and sync_cnt clears.
REQ-019 WAIT_B0: an FF byte is discarded and the state is held; a non-FF byte is stored as byte 0 and the next state is GET_B1.
REQ-020 GET_B0: any byte is stored as byte 0 and the next state is GET_B1.
REQ-021 GET_B1 and GET_B2: the byte is stored and the state advances one step.
REQ-022 GET_B3: the byte is stored and the frame completes; the next state is GET_B0.
REQ-023 On frame completion, if byte0==8'hFF and byte1==8'hFF (SYNC frame 16'hFFFF): no o_Frame_DV pulse, outputs unchanged, alignment kept.
REQ-024 Otherwise the outputs update and o_Frame_DV pulses exactly one cycle after the i_Rx_DV of byte 3 (latency 1 cycle).
REQ-025 Bytes are stored only on i_Rx_DV=1; the FSM never advances without i_Rx_DV.
REQ-026 i_Resync=1: next state is HUNT, sync_cnt clears, any partial frame is dropped, o_Err stays 0; a simultaneous i_Rx_DV byte is discarded.
REQ-027 i_Resync has priority over timeout; timeout has priority over a byte arriving in the same cycle.
REQ-028 Output registers change only on an accepted non-SYNC frame.
REQ-029 o_Frame_DV and o_Err are never high in the same cycle.

Reset
REQ-030 i_Rst_n=0 immediately forces state HUNT, sync_cnt=0, timer=0, o_Custom_Cmd=0, o_Cmd=0, o_Data=0, o_Frame_DV=0, o_Synced=0, o_Err=0.
REQ-031 Reset asserted mid-frame discards the partial frame; after release, the block re-hunts.
REQ-032 Reset release is synchronous to i_Clock at the block boundary; the first i_Rx_DV is honoured on the first rising edge after release.

Configuration
REQ-033 Macro UART_FRAME_TIMEOUT_EN gates the inter-byte timeout.
REQ-034 Defined: timer clears on every i_Rx_DV and counts in GET_B1..GET_B3 only.
REQ-035 Defined: at CLKS_PER_BIT*10*TIMEOUT_BYTES, o_Err pulses one cycle, the partial frame is dropped, the next state is HUNT and sync_cnt clears.
REQ-036 Undefined: no timer logic is present, o_Err is tied 0, and partial frames wait indefinitely; the port list is identical in both builds.

Verification (CLKS_PER_BIT=4 for simulation)
REQ-037 12x FF, then 12 34 AB CD -> one o_Frame_DV, o_Custom_Cmd=12, o_Cmd=34, o_Data=ABCD, o_Synced=1 from the 4th FF.
REQ-038 After alignment, send FF FF 00 01 then 01 02 03 04 -> no pulse for the first frame; pulse with 01/02/0304 for the second.
REQ-039 FF FF 55 FF FF FF FF 10 20 30 40 -> the 55 clears the hunt count; sync on the 4th later FF; frame 10/20/3040 is output.
REQ-040 Macro defined, aligned, send 10 20 then idle for more than 160 cycles -> o_Err pulses once, o_Synced=0, no o_Frame_DV.
REQ-041 Aligned; i_Resync asserted in the same cycle as the i_Rx_DV of byte 2 -> byte discarded, state HUNT, no o_Err, the block requires SYNC_MIN FF bytes again.
REQ-042 i_Rst_n pulsed low after byte 1 of a frame -> all outputs 0 asynchronously; the next 4 bytes produce no o_Frame_DV until re-synced.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: assembles 4-byte command frames (custom_cmd, cmd, data_hi, data_lo)
// from a byte-stream UART receiver. It hunts for a run of SYNC_MIN 8'hFF bytes
// to acquire alignment. It then emits each non-SYNC frame with a one-cycle o_Frame_DV.
// Optional feature macro: UART_FRAME_TIMEOUT_EN enables the inter-byte timeout
// that drops partial frames and pulses o_Err.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT  = 5000,
  parameter int SYNC_MIN      = 4,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Resync,
  output logic [7:0]  o_Custom_Cmd,
  output logic [7:0]  o_Cmd,
  output logic [15:0] o_Data,
  output logic        o_Frame_DV,
  output logic        o_Synced,
  output logic        o_Err
);

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] WAIT_B0 = 3'd1;
  localparam logic [2:0] GET_B0  = 3'd2;
  localparam logic [2:0] GET_B1  = 3'd3;
  localparam logic [2:0] GET_B2  = 3'd4;
  localparam logic [2:0] GET_B3  = 3'd5;

  localparam int SYNC_W = $clog2(SYNC_MIN + 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_MIN - 1);

  logic [2:0]        state;
  logic [SYNC_W-1:0] sync_cnt;
  logic [7:0]        byte0;
  logic [7:0]        byte1;
  logic [7:0]        byte2;
  logic              frame_dv;
  logic              err;
  logic              timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer;
  logic               counting;

  assign counting    = (state == GET_B1) || (state == GET_B2) || (state == GET_B3);
  assign timeout_hit = counting && (timer == TIMER_LAST);

  // Inter-byte timer: restarts on every byte, runs only while a frame is part-way in.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      timer <= '0;
    end else if (i_Resync || timeout_hit || i_Rx_DV || !counting) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame FSM and output registers: resync beats timeout, timeout beats an incoming byte.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= HUNT;
      sync_cnt     <= '0;
      byte0        <= '0;
      byte1        <= '0;
      byte2        <= '0;
      o_Custom_Cmd <= '0;
      o_Cmd        <= '0;
      o_Data       <= '0;
      frame_dv     <= 1'b0;
      err          <= 1'b0;
    end else begin
      frame_dv <= 1'b0;
      err      <= 1'b0;
      if (i_Resync) begin
        state    <= HUNT;
        sync_cnt <= '0;
      end else if (timeout_hit) begin
        err      <= 1'b1;
        state    <= HUNT;
        sync_cnt <= '0;
      end else if (i_Rx_DV) begin
        case (state)
          HUNT: begin
            if (i_Rx_Byte == 8'hFF) begin
              if (sync_cnt >= SYNC_LAST) begin
                state    <= WAIT_B0;
                sync_cnt <= '0;
              end else begin
                sync_cnt <= sync_cnt + SYNC_W'(1);
              end
            end else begin
              sync_cnt <= '0;
            end
          end
          WAIT_B0: begin
            if (i_Rx_Byte != 8'hFF) begin
              byte0 <= i_Rx_Byte;
              state <= GET_B1;
            end
          end
          GET_B0: begin
            byte0 <= i_Rx_Byte;
            state <= GET_B1;
          end
          GET_B1: begin
            byte1 <= i_Rx_Byte;
            state <= GET_B2;
          end
          GET_B2: begin
            byte2 <= i_Rx_Byte;
            state <= GET_B3;
          end
          GET_B3: begin
            state <= GET_B0;
            if (!((byte0 == 8'hFF) && (byte1 == 8'hFF))) begin
              o_Custom_Cmd <= byte0;
              o_Cmd        <= byte1;
              o_Data       <= {byte2, i_Rx_Byte};
              frame_dv     <= 1'b1;
            end
          end
          default: begin
            state    <= HUNT;
            sync_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign o_Frame_DV = frame_dv;
  assign o_Err      = err;
  assign o_Synced   = (state != HUNT);

endmodule
